// File: rtl/cmac_lanes_if.sv
// Operand and result streams of the multi-lane MAC engine.
// The engine is the slave of the operand stream and drives the result stream.
interface cmac_lanes_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] data;
    logic [LANES*DATA_W-1:0] weight;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] result;
    logic [LANES-1:0]        sat_flag;

    modport master (
        output in_valid, data, weight, out_ready,
        input  in_ready, out_valid, result, sat_flag
    );

    modport slave (
        input  in_valid, data, weight, out_ready,
        output in_ready, out_valid, result, sat_flag
    );
endinterface

// File: rtl/cmac_lanes.sv
// LANES signed fixed-point MAC lanes sharing one control FSM and op count.
// Each lane accumulates op_num products (plus optional bias), then rescales, saturates, ReLUs.
module cmac_lanes #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        op_num_i,
    input  logic                    relu_en_i,
    input  logic                    bias_en_i,
    input  logic [LANES*DATA_W-1:0] bias_i,
    cmac_lanes_if.slave             bus,
    output logic                    busy_o
);
    localparam int unsigned PW = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StOut} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         op_num_q, remaining_q;
    logic                     relu_q, bias_en_q;
    logic [LANES*DATA_W-1:0]  bias_q;
    logic                     in_ready, out_valid, accept;
    logic                     v0_q, v1_q;
    logic [DATA_W-1:0]        opd_q [LANES];
    logic [DATA_W-1:0]        opw_q [LANES];
    logic [PW-1:0]            prod_q [LANES];
    logic signed [ACC_W-1:0]  acc_q [LANES];
    logic signed [ACC_W-1:0]  shifted [LANES];
    logic [DATA_W-1:0]        lane_res [LANES];
    logic [LANES*DATA_W-1:0]  conv_res, result_q;
    logic [LANES-1:0]         conv_sat, sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_i) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (remaining_q == '0) state_d = StDrain;
            StDrain: if (!v0_q && !v1_q) state_d = StOut;
            StOut:   if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StRun) && (remaining_q != '0);
        out_valid = (state_q == StOut);
        busy_o    = (state_q != StIdle);
    end

    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.sat_flag  = sat_q;

    // Rescale to result format, clip to DATA_W, then ReLU on the clipped value.
    always_comb begin
        conv_res = '0;
        conv_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            shifted[i]  = acc_q[i] >>> FRAC_W;
            lane_res[i] = shifted[i][DATA_W-1:0];
            if (shifted[i] > SatMax) begin
                lane_res[i] = SatMax[DATA_W-1:0];
                conv_sat[i] = 1'b1;
            end else if (shifted[i] < SatMin) begin
                lane_res[i] = SatMin[DATA_W-1:0];
                conv_sat[i] = 1'b1;
            end
            if (relu_q && lane_res[i][DATA_W-1]) lane_res[i] = '0;
            conv_res[i*DATA_W +: DATA_W] = lane_res[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_num_q    <= '0;
            remaining_q <= '0;
            relu_q      <= 1'b0;
            bias_en_q   <= 1'b0;
            bias_q      <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            result_q    <= '0;
            sat_q       <= '0;
            for (int i = 0; i < LANES; i++) begin
                opd_q[i]  <= '0;
                opw_q[i]  <= '0;
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            if (state_q == StIdle && start_i) begin
                op_num_q  <= op_num_i;
                relu_q    <= relu_en_i;
                bias_en_q <= bias_en_i;
                bias_q    <= bias_i;
            end
            if (state_q == StLoad) begin
                remaining_q <= op_num_q;
            end else if (accept) begin
                remaining_q <= remaining_q - 1'b1;
            end
            // Operand capture, product, accumulate: a beat lands in acc two edges after accept.
            v0_q <= accept;
            v1_q <= v0_q;
            for (int i = 0; i < LANES; i++) begin
                if (accept) begin
                    opd_q[i] <= bus.data[i*DATA_W +: DATA_W];
                    opw_q[i] <= bus.weight[i*DATA_W +: DATA_W];
                end
                if (v0_q) begin
                    prod_q[i] <= {{DATA_W{opd_q[i][DATA_W-1]}}, opd_q[i]} *
                                 {{DATA_W{opw_q[i][DATA_W-1]}}, opw_q[i]};
                end
                if (state_q == StLoad) begin
                    acc_q[i] <= bias_en_q ?
                        ({{(ACC_W-DATA_W){bias_q[i*DATA_W+DATA_W-1]}},
                          bias_q[i*DATA_W +: DATA_W]} << FRAC_W) : '0;
                end else if (v1_q) begin
                    acc_q[i] <= acc_q[i] + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
                end
            end
            if (state_q == StDrain && state_d == StOut) begin
                result_q <= conv_res;
                sat_q    <= conv_sat;
            end
        end
    end
endmodule
